// File: rtl/rv_pkg.sv
// Shared encodings for the rv_mdp multicycle datapath and its rv_mdu multiply/divide unit.
package rv_pkg;

  typedef enum logic [1:0] {WB_MDR, WB_ALUOUT, WB_PC, WB_MDU} wbsel_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} immsel_e;
  typedef enum logic [1:0] {A_REG, A_PCC, A_ALUOUT, A_ZERO} asel_e;
  typedef enum logic [1:0] {B_REG, B_IMM, B_ALLONES, B_FOUR} bsel_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alusel_e;
  typedef enum logic [1:0] {MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU} mdu_op_e;

  localparam logic PCSRC_PC4 = 1'b0;
  localparam logic PCSRC_ALU = 1'b1;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mdu_state_e;

endpackage

// File: rtl/rv_mdp_if.sv
// Bus bundle between the rv_mdp datapath (slave) and the memories/controller (master).
interface rv_mdp_if #(
  parameter int unsigned DPWIDTH = 32
);
  logic [DPWIDTH-1:0] imem_addr;
  logic [DPWIDTH-1:0] imem_datain;
  logic [DPWIDTH-1:0] dmem_addr;
  logic [DPWIDTH-1:0] dmem_dataout;
  logic [DPWIDTH-1:0] dmem_datain;
  logic [DPWIDTH-1:0] instr;
  logic               zero;
  logic               pcsource;
  logic               pcwrite;
  logic               pccen;
  logic               irwrite;
  logic               regwen;
  logic               mdrwrite;
  logic [1:0]         wbsel;
  logic [2:0]         immsel;
  logic [1:0]         asel;
  logic [1:0]         bsel;
  logic [3:0]         alusel;
  logic               mdu_start;
  logic [1:0]         mdu_op;
  logic               mdu_busy;
  logic               mdu_done;

  modport slave (
    input  imem_datain, dmem_datain,
    input  pcsource, pcwrite, pccen, irwrite, regwen, mdrwrite,
    input  wbsel, immsel, asel, bsel, alusel, mdu_start, mdu_op,
    output imem_addr, dmem_addr, dmem_dataout, instr, zero, mdu_busy, mdu_done
  );

  modport master (
    output imem_datain, dmem_datain,
    output pcsource, pcwrite, pccen, irwrite, regwen, mdrwrite,
    output wbsel, immsel, asel, bsel, alusel, mdu_start, mdu_op,
    input  imem_addr, dmem_addr, dmem_dataout, instr, zero, mdu_busy, mdu_done
  );
endinterface

// File: rtl/rv_mdu.sv
// Iterative radix-2 multiply/divide unit: one bit per cycle, start/busy/done handshake.
// Divider datapath is present only when RV_MDU_DIV_EN is defined.
module rv_mdu
  import rv_pkg::*;
#(
  parameter int unsigned DPWIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  mdu_op_e            i_op,
  input  logic [DPWIDTH-1:0] i_a,
  input  logic [DPWIDTH-1:0] i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [DPWIDTH-1:0] o_result
);

  localparam int unsigned CW = $clog2(DPWIDTH);

  mdu_state_e         r_state;
  mdu_state_e         w_next;
  mdu_op_e            r_op;
  logic [CW-1:0]      r_cnt;
  logic [DPWIDTH:0]   r_hi;
  logic [DPWIDTH-1:0] r_lo;
  logic [DPWIDTH-1:0] r_m;
  logic [DPWIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_last;
  logic               w_is_div;
  logic [DPWIDTH:0]   w_mul_sum;
  logic [DPWIDTH:0]   w_hi_nxt;
  logic [DPWIDTH-1:0] w_lo_nxt;

  assign w_accept = (r_state == MDU_IDLE) && i_start;
  assign w_last   = (r_cnt == CW'(DPWIDTH - 1));
  assign w_is_div = (i_op == MDU_DIVU) || (i_op == MDU_REMU);

  // Shift-add: {hi,lo} shifts right each step, lo starts as the multiplier.
  assign w_mul_sum = r_hi + (r_lo[0] ? {1'b0, r_m} : '0);

`ifdef RV_MDU_DIV_EN
  logic [DPWIDTH:0]   w_div_shift;
  logic [DPWIDTH+1:0] w_div_diff;
  logic               w_div_qbit;

  // Restoring step; divisor 0 never borrows, giving all-ones quotient and remainder = dividend.
  assign w_div_shift = {r_hi[DPWIDTH-1:0], r_lo[DPWIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_m};
  assign w_div_qbit  = ~w_div_diff[DPWIDTH+1];

  always_comb begin
    if ((r_op == MDU_DIVU) || (r_op == MDU_REMU)) begin
      w_hi_nxt = w_div_qbit ? w_div_diff[DPWIDTH:0] : w_div_shift;
      w_lo_nxt = {r_lo[DPWIDTH-2:0], w_div_qbit};
    end else begin
      w_hi_nxt = {1'b0, w_mul_sum[DPWIDTH:1]};
      w_lo_nxt = {w_mul_sum[0], r_lo[DPWIDTH-1:1]};
    end
  end
`else
  always_comb begin
    w_hi_nxt = {1'b0, w_mul_sum[DPWIDTH:1]};
    w_lo_nxt = {w_mul_sum[0], r_lo[DPWIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MDU_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MDU_IDLE: begin
        if (i_start) begin
`ifdef RV_MDU_DIV_EN
          w_next = MDU_RUN;
`else
          w_next = w_is_div ? MDU_DONE : MDU_RUN;
`endif
        end
      end
      MDU_RUN:  if (w_last) w_next = MDU_DONE;
      MDU_DONE: w_next = MDU_IDLE;
      default:  w_next = MDU_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == MDU_RUN);
    o_done = (r_state == MDU_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MDU_MUL;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= i_op;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= w_is_div ? i_a : i_b;
      r_m   <= w_is_div ? i_b : i_a;
`ifndef RV_MDU_DIV_EN
      if (w_is_div) r_result <= '0;
`endif
    end else if (r_state == MDU_RUN) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_result <= ((r_op == MDU_MUL) || (r_op == MDU_DIVU)) ? w_lo_nxt
                                                              : w_hi_nxt[DPWIDTH-1:0];
      end
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/rv_mdp.sv
// Parametrised multicycle RISC-V datapath (RV32I/RV32E register file) with side-by-side MDU.
// Divider support in the MDU is enabled by defining RV_MDU_DIV_EN.
module rv_mdp
  import rv_pkg::*;
#(
  parameter int unsigned DPWIDTH = 32,
  parameter int unsigned RFSIZE  = 32
) (
  input logic     clk,
  input logic     rst_n,
  rv_mdp_if.slave bus
);

  localparam int unsigned SHW  = $clog2(DPWIDTH);
  localparam int unsigned RFAW = $clog2(RFSIZE);

  logic [DPWIDTH-1:0] r_pc, r_pcc, r_ir, r_a, r_b, r_aluout, r_mdr;
  logic [DPWIDTH-1:0] r_rf [RFSIZE];

  logic [31:0]        w_ir32;
  logic [31:0]        w_imm32;
  logic [DPWIDTH-1:0] w_imm;
  logic [4:0]         w_rs1, w_rs2, w_rd;
  logic               w_rs1_ok, w_rs2_ok, w_rd_ok;
  logic [DPWIDTH-1:0] w_rs1_val, w_rs2_val;
  logic [DPWIDTH-1:0] w_alu_a, w_alu_b, w_alu_res, w_wbdata, w_mdu_result;
  logic [SHW-1:0]     w_shamt;
  logic               w_lt;
  logic               w_unused;

  // Instruction fields are always taken from a 32-bit view of ir.
  if (DPWIDTH >= 32) begin : g_ir_wide
    assign w_ir32 = r_ir[31:0];
  end else begin : g_ir_narrow
    assign w_ir32 = {{(32 - DPWIDTH){1'b0}}, r_ir};
  end

  assign w_rs1    = w_ir32[19:15];
  assign w_rs2    = w_ir32[24:20];
  assign w_rd     = w_ir32[11:7];
  assign w_unused = ^w_ir32[6:0];

  if (RFSIZE < 32) begin : g_rf_partial
    assign w_rs1_ok = (w_rs1 != '0) && (w_rs1 < 5'(RFSIZE));
    assign w_rs2_ok = (w_rs2 != '0) && (w_rs2 < 5'(RFSIZE));
    assign w_rd_ok  = (w_rd  != '0) && (w_rd  < 5'(RFSIZE));
  end else begin : g_rf_full
    assign w_rs1_ok = (w_rs1 != '0);
    assign w_rs2_ok = (w_rs2 != '0);
    assign w_rd_ok  = (w_rd  != '0);
  end

  assign w_rs1_val = w_rs1_ok ? r_rf[w_rs1[RFAW-1:0]] : '0;
  assign w_rs2_val = w_rs2_ok ? r_rf[w_rs2[RFAW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (bus.regwen && w_rd_ok) r_rf[w_rd[RFAW-1:0]] <= w_wbdata;
  end

  always_comb begin
    case (immsel_e'(bus.immsel))
      IMM_S:   w_imm32 = {{20{w_ir32[31]}}, w_ir32[31:25], w_ir32[11:7]};
      IMM_B:   w_imm32 = {{19{w_ir32[31]}}, w_ir32[31], w_ir32[7], w_ir32[30:25],
                          w_ir32[11:8], 1'b0};
      IMM_J:   w_imm32 = {{11{w_ir32[31]}}, w_ir32[31], w_ir32[19:12], w_ir32[20],
                          w_ir32[30:21], 1'b0};
      IMM_U:   w_imm32 = {w_ir32[31:12], 12'b0};
      default: w_imm32 = {{20{w_ir32[31]}}, w_ir32[31:20]};
    endcase
  end

  assign w_imm = DPWIDTH'($signed(w_imm32));

  always_comb begin
    case (asel_e'(bus.asel))
      A_PCC:    w_alu_a = r_pcc;
      A_ALUOUT: w_alu_a = r_aluout;
      A_ZERO:   w_alu_a = '0;
      default:  w_alu_a = r_a;
    endcase
    case (bsel_e'(bus.bsel))
      B_IMM:     w_alu_b = w_imm;
      B_ALLONES: w_alu_b = '1;
      B_FOUR:    w_alu_b = DPWIDTH'(4);
      default:   w_alu_b = r_b;
    endcase
  end

  always_comb begin
    w_shamt = w_alu_b[SHW-1:0];
    w_lt    = $signed(w_alu_a) < $signed(w_alu_b);
    case (alusel_e'(bus.alusel))
      ALU_SUB:  w_alu_res = w_alu_a - w_alu_b;
      ALU_SLL:  w_alu_res = w_alu_a << w_shamt;
      ALU_SLT:  w_alu_res = {{(DPWIDTH-1){1'b0}}, w_lt};
      ALU_SLTU: w_alu_res = {{(DPWIDTH-1){1'b0}}, (w_alu_a < w_alu_b)};
      ALU_XOR:  w_alu_res = w_alu_a ^ w_alu_b;
      ALU_SRL:  w_alu_res = w_alu_a >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(w_alu_a) >>> w_shamt);
      ALU_OR:   w_alu_res = w_alu_a | w_alu_b;
      ALU_AND:  w_alu_res = w_alu_a & w_alu_b;
      default:  w_alu_res = w_alu_a + w_alu_b;
    endcase
  end

  always_comb begin
    w_wbdata = r_aluout;
    case (wbsel_e'(bus.wbsel))
      WB_MDR:  w_wbdata = r_mdr;
      WB_PC:   w_wbdata = r_pc;
      WB_MDU:  w_wbdata = w_mdu_result;
      default: w_wbdata = r_aluout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_pcc    <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      if (bus.pcwrite)  r_pc  <= (bus.pcsource == PCSRC_ALU) ? r_aluout : r_pc + DPWIDTH'(4);
      if (bus.pccen)    r_pcc <= r_pc;
      if (bus.irwrite)  r_ir  <= bus.imem_datain;
      if (bus.mdrwrite) r_mdr <= bus.dmem_datain;
      r_a      <= w_rs1_val;
      r_b      <= w_rs2_val;
      r_aluout <= w_alu_res;
    end
  end

  rv_mdu #(.DPWIDTH(DPWIDTH)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (bus.mdu_start),
    .i_op     (mdu_op_e'(bus.mdu_op)),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_busy   (bus.mdu_busy),
    .o_done   (bus.mdu_done),
    .o_result (w_mdu_result)
  );

  assign bus.imem_addr    = r_pc;
  assign bus.dmem_addr    = r_aluout;
  assign bus.dmem_dataout = r_b;
  assign bus.instr        = r_ir;
  assign bus.zero         = (w_alu_res == '0);

endmodule

// File: tb/tb_rv_mdp.sv
// Scoreboard bench for rv_mdp at DPWIDTH=32/RV32I; expectations follow RV_MDU_DIV_EN.
module tb_rv_mdp;
  import rv_pkg::*;

  localparam int unsigned W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_mdp_if #(.DPWIDTH(W)) bus();

  rv_mdp #(.DPWIDTH(W), .RFSIZE(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string          tag;
    logic [W-1:0]   val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [W-1:0] got);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got 0x%0h, expected no output", got);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, got, e.val);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] word);
    bus.imem_datain = word;
    bus.irwrite     = 1'b1;
    tick();
    bus.irwrite     = 1'b0;
  endtask

  task automatic wb_alu(input logic [31:0] word, input logic [2:0] isel);
    load_ir(word);
    bus.asel   = A_ZERO;
    bus.bsel   = B_IMM;
    bus.immsel = isel;
    bus.alusel = ALU_ADD;
    tick();
    bus.regwen = 1'b1;
    bus.wbsel  = WB_ALUOUT;
    tick();
    bus.regwen = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [W-1:0] v);
    load_ir(enc_r(5'd0, 5'd0, r));
    tick();
    v = bus.dmem_dataout;
  endtask

  task automatic alu_chk(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [3:0] op, input logic [W-1:0] exp);
    load_ir(enc_r(5'd0, rs1, rs2));
    bus.asel   = A_REG;
    bus.bsel   = B_REG;
    bus.alusel = op;
    tick();
    sb_push(tag, exp);
    tick();
    sb_pop_check(bus.dmem_addr);
  endtask

  task automatic imm_chk(input string tag, input logic [31:0] word, input logic [2:0] isel,
                         input logic [W-1:0] exp);
    load_ir(word);
    bus.asel   = A_ZERO;
    bus.bsel   = B_IMM;
    bus.immsel = isel;
    bus.alusel = ALU_ADD;
    sb_push(tag, exp);
    tick();
    sb_pop_check(bus.dmem_addr);
  endtask

  task automatic mdu_run(input string tag, input logic [1:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [W-1:0] exp, input int exp_lat,
                         input bit poke_busy);
    int          n;
    bit          seen;
    logic [W-1:0] v;
    load_ir(enc_r(5'd7, rs1, rs2));
    tick();
    bus.mdu_op    = op;
    bus.mdu_start = 1'b1;
    sb_push(tag, exp);
    tick();
    bus.mdu_start = 1'b0;
    n    = 1;
    seen = 1'b0;
    check_eq({tag, "_busy"}, bus.mdu_busy, (exp_lat > 1));
    while (n <= 100 && !seen) begin
      if (bus.mdu_done) begin
        seen = 1'b1;
      end else begin
        if (poke_busy && n == 5) begin
          bus.mdu_start = 1'b1;
          bus.mdu_op    = MDU_MULHU;
        end else begin
          bus.mdu_start = 1'b0;
        end
        tick();
        n++;
      end
    end
    bus.mdu_start = 1'b0;
    check_eq({tag, "_latency"}, n, exp_lat);
    bus.regwen = 1'b1;
    bus.wbsel  = WB_MDU;
    tick();
    bus.regwen = 1'b0;
    check_eq({tag, "_done_pulse"}, bus.mdu_done, 1'b0);
    read_reg(5'd7, v);
    sb_pop_check(v);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] v;
    int           dones;
    logic [W-1:0] q_exp, r_exp, q0_exp, r0_exp;
    int           div_lat;

    bus.imem_datain = '0;
    bus.dmem_datain = '0;
    bus.pcsource    = PCSRC_PC4;
    bus.pcwrite     = 1'b0;
    bus.pccen       = 1'b0;
    bus.irwrite     = 1'b0;
    bus.regwen      = 1'b0;
    bus.mdrwrite    = 1'b0;
    bus.wbsel       = WB_MDR;
    bus.immsel      = IMM_I;
    bus.asel        = A_REG;
    bus.bsel        = B_REG;
    bus.alusel      = ALU_ADD;
    bus.mdu_start   = 1'b0;
    bus.mdu_op      = MDU_MUL;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_eq("rst_pc", bus.imem_addr, 0);
    check_eq("rst_instr", bus.instr, 0);
    check_eq("rst_aluout", bus.dmem_addr, 0);
    check_eq("rst_b", bus.dmem_dataout, 0);
    check_eq("rst_busy", bus.mdu_busy, 0);
    check_eq("rst_done", bus.mdu_done, 0);

    bus.pcwrite = 1'b1;
    tick();
    tick();
    bus.pcwrite = 1'b0;
    check_eq("pc_plus4", bus.imem_addr, 8);

    wb_alu(enc_i(5'd1, 5'd0, 12'd5), IMM_I);
    wb_alu(enc_i(5'd2, 5'd0, 12'd7), IMM_I);
    alu_chk("add_x1_x2", 5'd1, 5'd2, ALU_ADD, 32'd12);
    check_eq("b_reads_x2", bus.dmem_dataout, 7);

    bus.pcsource = PCSRC_ALU;
    bus.pcwrite  = 1'b1;
    tick();
    bus.pcwrite  = 1'b0;
    bus.pcsource = PCSRC_PC4;
    check_eq("pc_from_alu", bus.imem_addr, 12);

    bus.pccen = 1'b1;
    tick();
    bus.pccen = 1'b0;
    bus.asel  = A_PCC;
    bus.bsel  = B_FOUR;
    tick();
    check_eq("pcc_plus4", bus.dmem_addr, 16);

    wb_alu(enc_i(5'd0, 5'd0, 12'd9), IMM_I);
    alu_chk("x0_reads_zero", 5'd0, 5'd0, ALU_ADD, 32'd0);
    alu_chk("sub", 5'd1, 5'd2, ALU_SUB, 32'hFFFF_FFFE);
    alu_chk("xor", 5'd1, 5'd2, ALU_XOR, 32'd2);
    alu_chk("and", 5'd1, 5'd2, ALU_AND, 32'd5);

    imm_chk("imm_b_sign", 32'h8000_0000, IMM_B, 32'hFFFF_F000);
    imm_chk("imm_j_sign", 32'h8000_0000, IMM_J, 32'hFFF0_0000);
    imm_chk("imm_s_low", 32'h0000_0F80, IMM_S, 32'h0000_001F);
    imm_chk("imm_b_low", 32'h0000_0F80, IMM_B, 32'h0000_081E);
    imm_chk("imm_j_mid", 32'h7FE0_0000, IMM_J, 32'h0000_07FE);
    imm_chk("imm_j_hi", 32'h000F_F000, IMM_J, 32'h000F_F000);
    imm_chk("imm_j_b11", 32'h0010_0000, IMM_J, 32'h0000_0800);
    imm_chk("imm_u", 32'h7FE0_0000, IMM_U, 32'h7FE0_0000);
    imm_chk("imm_s_mid", 32'h7FE0_0000, IMM_S, 32'h0000_07E0);

    wb_alu(enc_u(5'd3, 20'h80000), IMM_U);
    wb_alu(enc_i(5'd4, 5'd0, 12'd33), IMM_I);
    wb_alu(enc_i(5'd5, 5'd0, 12'hFFF), IMM_I);
    wb_alu(enc_i(5'd6, 5'd0, 12'd1), IMM_I);
    alu_chk("lui", 5'd3, 5'd0, ALU_ADD, 32'h8000_0000);
    alu_chk("sra_mask", 5'd3, 5'd4, ALU_SRA, 32'hC000_0000);
    alu_chk("srl_mask", 5'd3, 5'd4, ALU_SRL, 32'h4000_0000);
    alu_chk("sll_mask", 5'd6, 5'd4, ALU_SLL, 32'd2);
    alu_chk("slt_signed", 5'd5, 5'd6, ALU_SLT, 32'd1);
    check_eq("zero_low", bus.zero, 1'b0);
    alu_chk("sltu", 5'd5, 5'd6, ALU_SLTU, 32'd0);
    check_eq("zero_high", bus.zero, 1'b1);

    bus.dmem_datain = 32'hCAFE_0123;
    bus.mdrwrite    = 1'b1;
    tick();
    bus.mdrwrite    = 1'b0;
    bus.dmem_datain = '0;
    load_ir(enc_r(5'd8, 5'd0, 5'd0));
    bus.regwen = 1'b1;
    bus.wbsel  = WB_MDR;
    sb_push("mdr_writeback", 32'hCAFE_0123);
    tick();
    bus.regwen = 1'b0;
    read_reg(5'd8, v);
    sb_pop_check(v);

    wb_alu(enc_i(5'd1, 5'd0, 12'hFFF), IMM_I);
    wb_alu(enc_i(5'd2, 5'd0, 12'hFFF), IMM_I);
    mdu_run("mul_ones", MDU_MUL, 5'd1, 5'd2, 32'h0000_0001, 33, 1'b1);
    mdu_run("mulhu_ones", MDU_MULHU, 5'd1, 5'd2, 32'hFFFF_FFFE, 33, 1'b0);

`ifdef RV_MDU_DIV_EN
    q_exp   = 32'd14;
    r_exp   = 32'd2;
    q0_exp  = 32'hFFFF_FFFF;
    r0_exp  = 32'd5;
    div_lat = 33;
`else
    q_exp   = 32'd0;
    r_exp   = 32'd0;
    q0_exp  = 32'd0;
    r0_exp  = 32'd0;
    div_lat = 1;
`endif
    wb_alu(enc_i(5'd1, 5'd0, 12'd100), IMM_I);
    wb_alu(enc_i(5'd2, 5'd0, 12'd7), IMM_I);
    mdu_run("divu_100_7", MDU_DIVU, 5'd1, 5'd2, q_exp, div_lat, 1'b0);
    mdu_run("remu_100_7", MDU_REMU, 5'd1, 5'd2, r_exp, div_lat, 1'b0);
    wb_alu(enc_i(5'd1, 5'd0, 12'd5), IMM_I);
    mdu_run("divu_by0", MDU_DIVU, 5'd1, 5'd0, q0_exp, div_lat, 1'b0);
    mdu_run("remu_by0", MDU_REMU, 5'd1, 5'd0, r0_exp, div_lat, 1'b0);

    // Abort an in-flight multiply with reset; x7 is preloaded so a zero result is visible.
    wb_alu(enc_i(5'd7, 5'd0, 12'h055), IMM_I);
    wb_alu(enc_i(5'd1, 5'd0, 12'd9), IMM_I);
    wb_alu(enc_i(5'd2, 5'd0, 12'd9), IMM_I);
    bus.pcwrite = 1'b1;
    tick();
    bus.pcwrite = 1'b0;
    load_ir(enc_r(5'd7, 5'd1, 5'd2));
    tick();
    bus.mdu_op    = MDU_MUL;
    bus.mdu_start = 1'b1;
    tick();
    bus.mdu_start = 1'b0;
    repeat (9) tick();
    check_eq("run10_busy", bus.mdu_busy, 1'b1);
    rst_n = 1'b0;
    #2;
    check_eq("abort_pc", bus.imem_addr, 0);
    check_eq("abort_instr", bus.instr, 0);
    check_eq("abort_aluout", bus.dmem_addr, 0);
    check_eq("abort_busy", bus.mdu_busy, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("first_fetch", bus.imem_addr, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mdu_done) dones++;
      tick();
    end
    check_eq("abort_no_done", dones, 0);
    check_eq("abort_busy_stays", bus.mdu_busy, 0);
    load_ir(enc_r(5'd7, 5'd0, 5'd0));
    bus.regwen = 1'b1;
    bus.wbsel  = WB_MDU;
    sb_push("abort_result", 32'd0);
    tick();
    bus.regwen = 1'b0;
    read_reg(5'd7, v);
    sb_pop_check(v);

    wb_alu(enc_i(5'd1, 5'd0, 12'd3), IMM_I);
    wb_alu(enc_i(5'd2, 5'd0, 12'd4), IMM_I);
    mdu_run("mul_3x4", MDU_MUL, 5'd1, 5'd2, 32'd12, 33, 1'b0);

    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mdp.md
# rv_mdp

Parametrised multicycle RISC-V datapath, the successor to the fixed 32-bit datapath. It is generic in datapath width and register-file depth (RV32I or RV32E). It adds U-type immediates, a fourth ALU-A/B source, and correct shift-amount masking. An iterative multiply/divide unit (MDU) sits beside the ALU with a start/busy/done handshake, and the external multicycle controller sequences it.

## Interface
- DPWIDTH, 32, datapath width; power of two, ≥16
- RFSIZE, 32, architectural registers (16 = RV32E, 32 = RV32I)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_addr / imem_datain  out / in  DPWIDTH  fetch address = pc / fetched word
- dmem_addr / dmem_dataout / dmem_datain  out / out / in  DPWIDTH  aluout / b / load data
- instr  out  DPWIDTH  ir contents
- zero  out  1  combinational alu_result == 0
- pcsource, pcwrite, pccen, irwrite, regwen, mdrwrite  in  1  as previous generation
- wbsel  in  2  MDR / ALUOUT / PC / MDU
- immsel  in  3  I / S / B / J / U
- asel  in  2  REG / PCC / ALUOUT / ZERO
- bsel  in  2  REG / IMM / ALLONES / FOUR
- alusel  in  4  ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (others → ADD)
- mdu_start  in  1  launch MDU on a, b
- mdu_op  in  2  MUL / MULHU / DIVU / REMU
- mdu_busy  out  1  MDU iterating
- mdu_done  out  1  one-cycle pulse, mdu result valid

## Operation
- pc: pcwrite loads aluout (pcsource=ALU) or pc+4. pcc ← pc on pccen. ir ← imem_datain on irwrite. mdr ← dmem_datain on mdrwrite.
- Register file: x0 reads 0 and ignores writes. Addresses ≥ RFSIZE read 0 and drop writes. Write occurs on regwen. The RF array is not reset.
- a/b latch RF[rs1]/RF[rs2] every cycle. aluout latches alu_result every cycle.
- Immediates are sign-extended from ir[31]. U = {ir[31:12], 12'b0}, extended if DPWIDTH > 32.
- Shifts use alu_b[$clog2(DPWIDTH)-1:0] only. SRA and SLT are signed.
- MDU is radix-2 and computes one bit per cycle.
  - MUL returns the low half of the unsigned product. MULHU returns the high half.
  - DIVU/REMU use restoring division.
  - Divide by zero: quotient = all ones, remainder = dividend.
- MDU states: IDLE → RUN (DPWIDTH cycles) → DONE (1 cycle) → IDLE.
- mdu_start is accepted only in IDLE; it is ignored in RUN and DONE. Operands and op are captured at acceptance.
- The MDU result register holds its value until the next accepted start.

## Timing
- Reset: pc, pcc, ir, a, b, aluout, mdr, MDU result = 0. mdu_busy = mdu_done = 0. FSM goes to IDLE.
- RF read latency is 1 cycle (a/b). ALU to aluout is 1 cycle. The mdr load is 1 cycle.
- MDU start is sampled at edge 0. mdu_busy is high for cycles 1..DPWIDTH. mdu_done and the valid result appear in cycle DPWIDTH+1. Total latency is DPWIDTH+1.
- A start in the DONE cycle is ignored. The controller re-asserts it in the next cycle.
- When regwen is asserted with wbsel=MDU during the DONE cycle, the MDU result is written that edge.
- rst_n asserted mid-RUN aborts the operation. No done pulse follows.

## Configuration
- RV_MDU_DIV_EN defined: divider datapath present, and DIVU/REMU behave as above.
- RV_MDU_DIV_EN undefined: no divider logic.
  - DIVU/REMU are accepted, mdu_busy stays 0, and mdu_done pulses in cycle 1 with result 0.
  - MUL/MULHU timing is unchanged.

## Structure
- rv_pkg holds the following:
  - wbsel, immsel, asel, bsel, alusel, mdu_op enums
  - pcsource encodings
  - MDU FSM state typedef
- rv_mdu is the one sub-module. It owns the FSM, iteration counter, accumulator/quotient registers and the `ifdef RV_MDU_DIV_EN` block.
- The rest stays flat in rv_mdp.

## Test plan
- Reset check: rst_n low mid-run → pc=0, instr=0, aluout=0, mdu_busy=0. After release, first fetch at imem_addr=0.
- Register load and ALU add:
  - Writeback asel=ZERO, bsel=IMM, I-imm 5 to x1; same with 7 to x2.
  - Then asel/bsel=REG with ADD → aluout=12.
  - A write to x0 leaves x0 reading 0.
- Shift masking (DPWIDTH=32): a=0x80000000, b=33, SRA → 0xC0000000; SRL → 0x40000000. SLT of 0xFFFFFFFF vs 1 → 1; SLTU → 0.
- Multiply: 0xFFFFFFFF × 0xFFFFFFFF.
  - MUL → 0x00000001; MULHU → 0xFFFFFFFE.
  - mdu_done exactly 33 cycles after start.
  - A start during busy is ignored.
- Divide (macro on): DIVU 100/7 → 14; REMU → 2. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. With the macro off: done in cycle 1, result 0.
- Reset mid-MDU: pulse rst_n at RUN cycle 10 → busy=0, no done pulse, result 0. A following MUL 3×4 → 12.
